fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage: the producer end of the opcode interface consumed by the decode/control stage. It generates the PC, reads instruction memory over a req/ack handshake, buffers fetched words in a small FIFO, and presents them to decode with a valid/ready handshake. It handles redirects (BEQ taken, JMP, RES) from later stages by flushing and refetching. Bits [INSTR_W-1:INSTR_W-4] of each presented word are the 4-bit opcode.

## Interface
- INSTR_W, 16, instruction width; opcode = top 4 bits
- PC_W, 12, PC/word-address width; legal range 4..12
- RESET_PC, 0, first fetch address after reset
- DEPTH, 2, FIFO entries; legal values 2 or 4
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch word address
- imem_ack  in  1  request completes this cycle; imem_rdata valid
- imem_rdata  in  INSTR_W  fetched word
- redirect_valid  in  1  flush and refetch from redirect_pc
- redirect_pc  in  PC_W  new fetch address
- if_valid  out  1  FIFO head valid
- id_ready  in  1  decode accepts head
- if_instr  out  INSTR_W  head instruction
- if_pc  out  PC_W  address of head instruction
- if_jmp_taken  out  1  head is a JMP already redirected in fetch

## Operation
- States: FETCH (no request outstanding or issuing), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
- Request rule: in FETCH, imem_req=1 iff count<DEPTH; imem_addr=pc. Once imem_req=1, req and addr stay stable until imem_ack. At most one outstanding request.
- Completion: imem_req&imem_ack. In WAIT/FETCH, push {rdata, addr}; pc<=addr+1 (mod 2^PC_W, wraps to 0). In DROP, push nothing; pc keeps the redirect target.
- Back-to-back: if count after this cycle is still <DEPTH, imem_req stays 1 the next cycle with the new pc. Throughput: 1 word/cycle with same-cycle ack.
- Pop: if_valid&id_ready removes head. Push and pop in the same cycle keep count unchanged, including at count==DEPTH.
- Redirect: FIFO flushed (count<=0, if_valid=0 next cycle); pc<=redirect_pc. With no outstanding request, state stays FETCH and a request issues next cycle. With an outstanding request (not acked this cycle), state goes to DROP; the held request completes and its data is discarded; then FETCH at redirect_pc.
- Redirect and ack in the same cycle: redirect wins. The acked word is discarded; state FETCH; next request goes to redirect_pc.
- Redirect and pop in the same cycle: the pop is accepted by decode; the FIFO is flushed anyway.
- imem_ack with imem_req=0 is ignored.
- Reset (any cycle, including mid-request): state FETCH, pc<=RESET_PC, count 0. Any in-flight memory response is not waited for. Memory must tolerate an abandoned request.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, if_valid 0, if_instr 0, if_pc 0, if_jmp_taken 0.
- First request: cycle 1 after rst_n rises (imem_req=1, addr RESET_PC).
- Fetch latency: ack at cycle N gives if_valid at N+1 (registered FIFO, head driven from storage).
- Redirect at N (idle memory): imem_addr=redirect_pc with req=1 at N+1; with immediate ack, if_valid at N+2.
- if_instr, if_pc and if_jmp_taken are stable while if_valid&!id_ready.

## Configuration
- FETCH_JMP_PREDECODE_EN defined: on a kept completion with opcode 4'b1111 (JMP), pc<=rdata[PC_W-1:0] instead of addr+1. The word is pushed with if_jmp_taken=1. Decode must suppress its own JMP redirect when if_jmp_taken=1. A same-cycle external redirect still wins.
- Not defined: JMP fetches sequentially; if_jmp_taken tied 0.

## Test plan
- Reset, id_ready=1, ack same cycle -> addresses 0,1,2,3 on consecutive cycles; if_pc 0,1,2,3 from cycle 2.
- id_ready=0, DEPTH=2 -> exactly two acks accepted; imem_req drops to 0; if_instr holds first word; raising id_ready resumes fetch at addr 2.
- Ack delayed 3 cycles, redirect_valid to 0x40 in wait cycle 1 -> imem_addr held until ack; data discarded; next request addr 0x40; no stale if_valid.
- Redirect to 0x10 coincident with ack of addr 5 -> word 5 never appears; next imem_addr 0x10.
- pc=0xFFF sequential -> next fetch addr 0x000.
- With FETCH_JMP_PREDECODE_EN, word 0xF123 at addr 4 -> next imem_addr 0x123; head if_jmp_taken=1. Without the macro -> next addr 5; if_jmp_taken=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decode handshake bundle.
interface fetch_unit_if #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 12
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               if_valid;
    logic               id_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [PC_W-1:0]    if_pc;
    logic               if_jmp_taken;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_jmp_taken,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_jmp_taken,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem req/ack fetch, FIFO to decode, redirect flush.
// Optional FETCH_JMP_PREDECODE_EN: kept JMP words redirect the PC inside fetch.
module fetch_unit #(
    parameter int INSTR_W  = 16,
    parameter int PC_W     = 12,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input logic clk,
    input logic rst_n,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

    state_t             state, state_nx;
    logic               run;
    logic [PC_W-1:0]    pc, pc_nx, addr_q;
    logic [AW-1:0]      rd_ptr, wr_ptr;
    logic [CW-1:0]      count;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic               mem_jmp   [DEPTH];
    logic               req, done, push, pop, is_jmp;

`ifdef FETCH_JMP_PREDECODE_EN
    assign is_jmp = bus.imem_rdata[INSTR_W-1 -: 4] == 4'hF;
`else
    assign is_jmp = 1'b0;
`endif

    // run keeps imem_req low during reset and for the first cycle after it
    assign req  = run && (state != FETCH || count < CW'(DEPTH));
    assign done = req && bus.imem_ack;
    assign push = done && state != DROP && !bus.redirect_valid;
    assign pop  = bus.if_valid && bus.id_ready;

    assign bus.imem_req     = req;
    assign bus.imem_addr    = state == FETCH ? pc : addr_q;
    assign bus.if_valid     = count != '0;
    assign bus.if_instr     = bus.if_valid ? mem_instr[rd_ptr] : '0;
    assign bus.if_pc        = bus.if_valid ? mem_pc[rd_ptr] : '0;
    assign bus.if_jmp_taken = bus.if_valid && mem_jmp[rd_ptr];

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (bus.redirect_valid) begin
            state_nx = (!req || done) ? FETCH : DROP;
            pc_nx    = bus.redirect_pc;
        end else begin
            state_nx = (!req || done) ? FETCH : (state == DROP ? DROP : WAIT);
            if (push)
                pc_nx = is_jmp ? bus.imem_rdata[PC_W-1:0] : bus.imem_addr + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= FETCH;
            run    <= 1'b0;
            pc     <= PC_W'(RESET_PC);
            addr_q <= PC_W'(RESET_PC);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state  <= state_nx;
            run    <= 1'b1;
            pc     <= pc_nx;
            addr_q <= bus.imem_addr;
            if (bus.redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= bus.imem_addr;
            mem_jmp[wr_ptr]   <= is_jmp;
        end
    end
endmodule
